ettt_serializer: RTL

- Transmit-side counterpart of the deserializer / eight-to-thirty-two receive path.
- Accepts 32-bit words over a valid/ready handshake and emits them as a continuous 1-bit stream on t_clk, MSB first.
- Byte boundaries align to every 8th bit, so the receiver's divide-by-8 byte capture and 4-byte packing reassemble the word.
- Drives the serial line of the link test bench in place of an external pattern source.

---
 rtl/ettt_serializer_pkg.sv | 8 +
 rtl/ettt_serializer_piso.sv | 17 +
 rtl/ettt_serializer.sv | 82 ++++++++
 3 files changed

// File: rtl/ettt_serializer_pkg.sv
// ser_pkg: shared widths, state encoding and default sync byte for the serializer
package ser_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int PRE_LEN = 8;
  localparam logic [PRE_LEN-1:0] PREAMBLE = 8'hA5;
  typedef enum logic [1:0] {IDLE, PRE, SHIFT} state_t;
endpackage

// File: rtl/ettt_serializer_piso.sv
// piso_shreg: parallel-load shift-left register exposing its MSB
module piso_shreg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);
  logic [W-1:0] sr;
  // load wins over shift so a back-to-back reload replaces the drained word
  always_ff @(posedge clk)
    sr <= rst ? '0 : load ? din : shift ? {sr[W-2:0], 1'b0} : sr;
  assign msb = sr[W-1];
endmodule

// File: rtl/ettt_serializer.sv
// ettt_serializer: word-to-bitstream transmitter, MSB first; SER_PREAMBLE_EN adds a sync byte per frame
module ettt_serializer #(
  parameter int   WORD_W   = ser_pkg::WORD_W,
  parameter int   BYTE_W   = ser_pkg::BYTE_W,
  parameter logic IDLE_BIT = 1'b0
`ifdef SER_PREAMBLE_EN
  , parameter logic [ser_pkg::PRE_LEN-1:0] PREAMBLE = ser_pkg::PREAMBLE
`endif
) (
  input  logic              t_clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              data_out,
  output logic              data_out_valid,
  output logic              byte_strobe,
  output logic              frame_start,
  output logic              busy
);
  import ser_pkg::*;
  localparam int CW = $clog2(WORD_W);
  localparam int BW = $clog2(BYTE_W);
`ifdef SER_PREAMBLE_EN
  localparam state_t FIRST = PRE;
`else
  localparam state_t FIRST = SHIFT;
`endif
  state_t state, state_nx;
  logic [CW-1:0] bit_cnt, cnt_nx;
  logic last, accept, pay_msb;
  assign last = state == SHIFT && bit_cnt == CW'(WORD_W - 1);
  assign data_ready = !rst && (state == IDLE || last);
  assign accept = data_valid && data_ready;
  piso_shreg #(.W(WORD_W)) u_pay (
    .clk(t_clk), .rst(rst), .load(accept), .shift(state == SHIFT), .din(data_in), .msb(pay_msb)
  );
`ifdef SER_PREAMBLE_EN
  logic pre_msb;
  piso_shreg #(.W(PRE_LEN)) u_pre (
    .clk(t_clk), .rst(rst), .load(accept), .shift(state == PRE), .din(PREAMBLE), .msb(pre_msb)
  );
  assign data_out = state == SHIFT ? pay_msb : state == PRE ? pre_msb : IDLE_BIT;
  assign frame_start = state == PRE && bit_cnt == '0;
`else
  assign data_out = state == SHIFT ? pay_msb : IDLE_BIT;
  assign frame_start = data_out_valid && bit_cnt == '0;
`endif
  assign data_out_valid = state != IDLE;
  assign busy = state != IDLE;
  assign byte_strobe = data_out_valid && bit_cnt[BW-1:0] == '0;
  // state and bit counter registers
  always_ff @(posedge t_clk) begin
    state <= rst ? IDLE : state_nx;
    bit_cnt <= rst ? '0 : cnt_nx;
  end
  // next state: the counter restarts at every phase boundary and on reload
  always_comb begin
    state_nx = state;
    cnt_nx = bit_cnt + 1'b1;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        state_nx = accept ? FIRST : IDLE;
      end
`ifdef SER_PREAMBLE_EN
      PRE: if (bit_cnt == CW'(PRE_LEN - 1)) begin
        cnt_nx = '0;
        state_nx = SHIFT;
      end
`endif
      SHIFT: if (last) begin
        cnt_nx = '0;
        state_nx = accept ? FIRST : IDLE;
      end
      default: begin
        cnt_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end
endmodule
